// File: rtl/dram_arbiter.sv
// Round-robin arbiter that lets a CPU requester (A) and an IO requester (B)
// share one single-port data memory, one IDLE/ACCESS/DONE transaction at a time.
module dram_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              dram_write,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_data_in,
    input  logic [DATA_W-1:0] dram_data_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state;
    logic              last_owner;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              grant_b;

    // Owner encoding: 0 = port A, 1 = port B. On contention the port that did not win last time gets it.
    always_comb begin
        grant_b = b_req && (!a_req || !last_owner);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state      <= ACCESS;
                        owner      <= grant_b;
                        last_owner <= grant_b;
                        lat_we     <= grant_b ? b_we    : a_we;
                        lat_addr   <= grant_b ? b_addr  : a_addr;
                        lat_wdata  <= grant_b ? b_wdata : a_wdata;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    if (!lat_we) begin
                        if (owner) begin
                            b_rdata_q <= dram_data_out;
                        end else begin
                            a_rdata_q <= dram_data_out;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gating with reset aborts a transaction caught mid-flight: no write strobe, no ack.
    always_comb begin
        dram_write   = (state == ACCESS) && lat_we && !reset;
        dram_addr    = lat_addr;
        dram_data_in = lat_wdata;
        a_ack        = (state == DONE) && !owner && !reset;
        b_ack        = (state == DONE) && owner && !reset;
        a_rdata      = a_rdata_q;
        b_rdata      = b_rdata_q;
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: transaction-level reference model plus
// directed scenarios with hand-computed expectations and a small data memory.
module tb_dram_arbiter;

    localparam int AW = 24;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          dram_write;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_data_in;
    logic [DW-1:0] dram_data_out;

    int errors = 0;
    int checks = 0;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_ack        (a_ack),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_ack        (b_ack),
        .b_rdata      (b_rdata),
        .dram_write   (dram_write),
        .dram_addr    (dram_addr),
        .dram_data_in (dram_data_in),
        .dram_data_out(dram_data_out)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, write on the rising edge.
    logic [DW-1:0] env_mem [256];
    assign dram_data_out = env_mem[dram_addr[7:0]];
    always @(posedge clk) begin
        if (dram_write) env_mem[dram_addr[7:0]] <= dram_data_in;
    end

    function automatic logic [DW-1:0] preload_value(input int i);
        case (i)
            0:       preload_value = 8'd123;
            1:       preload_value = 8'd89;
            3:       preload_value = 8'd94;
            default: preload_value = 8'((i * 37 + 11) & 255);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one transaction at a time; tx_age counts cycles since the grant.
    bit            model_valid = 1'b0;
    int            tx_age;
    logic          model_last_b;
    logic          tx_b, tx_we;
    logic [AW-1:0] tx_addr;
    logic [DW-1:0] tx_wdata;
    logic [DW-1:0] exp_a_rdata, exp_b_rdata;
    logic [DW-1:0] model_mem [256];

    always @(posedge clk) begin
        if (reset) begin
            model_valid  = 1'b1;
            tx_age       = 0;
            model_last_b = 1'b1;
            tx_b         = 1'b0;
            tx_we        = 1'b0;
            tx_addr      = '0;
            tx_wdata     = '0;
            exp_a_rdata  = '0;
            exp_b_rdata  = '0;
        end else if (tx_age == 0) begin
            if (a_req || b_req) begin
                tx_b         = (a_req && b_req) ? !model_last_b : b_req;
                model_last_b = tx_b;
                tx_we        = tx_b ? b_we    : a_we;
                tx_addr      = tx_b ? b_addr  : a_addr;
                tx_wdata     = tx_b ? b_wdata : a_wdata;
                tx_age       = 1;
            end
        end else if (tx_age == 1) begin
            if (tx_we) model_mem[tx_addr[7:0]] = tx_wdata;
            else if (tx_b) exp_b_rdata = model_mem[tx_addr[7:0]];
            else exp_a_rdata = model_mem[tx_addr[7:0]];
            tx_age = 2;
        end else begin
            tx_age = 0;
        end
    end

    // Event log used by the directed checks.
    int            cycle = 0;
    int            a_ack_count = 0;
    int            b_ack_count = 0;
    int            wr_count = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    logic          ack_owner_q [$];
    int            ack_cycle_q [$];

    always @(negedge clk) begin
        cycle++;
        if (model_valid) begin
            checkOutput("a_ack", a_ack, (tx_age == 2) && !tx_b && !reset);
            checkOutput("b_ack", b_ack, (tx_age == 2) && tx_b && !reset);
            checkOutput("dram_write", dram_write, (tx_age == 1) && tx_we && !reset);
            checkOutput("dram_addr", dram_addr, tx_addr);
            checkOutput("dram_data_in", dram_data_in, tx_wdata);
            checkOutput("a_rdata", a_rdata, exp_a_rdata);
            checkOutput("b_rdata", b_rdata, exp_b_rdata);
        end
        if (a_ack === 1'b1) a_ack_count++;
        if (b_ack === 1'b1) b_ack_count++;
        if (a_ack === 1'b1 || b_ack === 1'b1) begin
            ack_owner_q.push_back(b_ack);
            ack_cycle_q.push_back(cycle);
        end
        if (dram_write === 1'b1) begin
            wr_count++;
            last_wr_addr = dram_addr;
            last_wr_data = dram_data_in;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic ar, input logic awe, input logic [AW-1:0] aa, input logic [DW-1:0] aw,
                                 input logic br, input logic bwe, input logic [AW-1:0] ba, input logic [DW-1:0] bw);
        a_req = ar; a_we = awe; a_addr = aa; a_wdata = aw;
        b_req = br; b_we = bwe; b_addr = ba; b_wdata = bw;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idleInputs();
        step(2);
        reset = 1'b0;
    endtask

    // Waits (bounded) for the chosen port's ack; latency is cycles from the request, 0 on timeout.
    task automatic waitAck(input logic port_b, output int latency);
        latency = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if ((port_b ? b_ack : a_ack) === 1'b1) begin
                latency = i;
                break;
            end
        end
        checkOutput(port_b ? "b_ack_seen" : "a_ack_seen", latency != 0, 1'b1);
    endtask

    task automatic runTransaction(input logic port_b, input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, output int latency);
        if (port_b) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, we, addr, wdata);
        else applyStimulus(1'b1, we, addr, wdata, 1'b0, 1'b0, '0, '0);
        waitAck(port_b, latency);
        idleInputs();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int wr_before;
        int a_before;
        int b_before;

        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = preload_value(i);
            model_mem[i] = preload_value(i);
        end
        idleInputs();
        doReset();

        $display("[TB] reset values");
        checkOutput("rst_a_ack", a_ack, 1'b0);
        checkOutput("rst_b_ack", b_ack, 1'b0);
        checkOutput("rst_a_rdata", a_rdata, 8'd0);
        checkOutput("rst_b_rdata", b_rdata, 8'd0);
        checkOutput("rst_dram_write", dram_write, 1'b0);
        checkOutput("rst_dram_addr", dram_addr, 24'd0);
        checkOutput("rst_dram_data_in", dram_data_in, 8'd0);

        $display("[TB] single read on A");
        b_before = b_ack_count;
        runTransaction(1'b0, 1'b0, 24'd0, 8'd0, lat);
        checkOutput("read_latency", lat, 2);
        checkOutput("read_a_rdata", a_rdata, 8'd123);
        checkOutput("read_no_b_ack", b_ack_count - b_before, 0);
        step(1);

        $display("[TB] write then read on B");
        wr_before = wr_count;
        runTransaction(1'b1, 1'b1, 24'd5, 8'hA5, lat);
        checkOutput("bwr_pulses", wr_count - wr_before, 1);
        checkOutput("bwr_addr", last_wr_addr, 24'd5);
        checkOutput("bwr_data", last_wr_data, 8'hA5);
        step(1);
        runTransaction(1'b1, 1'b0, 24'd5, 8'd0, lat);
        checkOutput("brd_b_rdata", b_rdata, 8'hA5);
        step(1);

        $display("[TB] contention after reset");
        doReset();
        ack_owner_q.delete();
        ack_cycle_q.delete();
        applyStimulus(1'b1, 1'b0, 24'd10, 8'd0, 1'b1, 1'b0, 24'd20, 8'd0);
        step(12);
        idleInputs();
        step(3);
        checkOutput("cont_ack_count", ack_owner_q.size(), 4);
        if (ack_owner_q.size() == 4) begin
            checkOutput("cont_owner0", ack_owner_q[0], 1'b0);
            checkOutput("cont_owner1", ack_owner_q[1], 1'b1);
            checkOutput("cont_owner2", ack_owner_q[2], 1'b0);
            checkOutput("cont_owner3", ack_owner_q[3], 1'b1);
            for (int i = 1; i < 4; i++)
                checkOutput("cont_spacing", ack_cycle_q[i] - ack_cycle_q[i-1], 3);
        end

        $display("[TB] address held stable during access");
        applyStimulus(1'b1, 1'b0, 24'd3, 8'd0, 1'b0, 1'b0, '0, '0);
        step(1);
        applyStimulus(1'b1, 1'b0, 24'd9, 8'd0, 1'b0, 1'b0, '0, '0);
        waitAck(1'b0, lat);
        idleInputs();
        checkOutput("stable_a_rdata", a_rdata, 8'd94);
        step(1);

        $display("[TB] reset during write");
        wr_before = wr_count;
        a_before  = a_ack_count;
        applyStimulus(1'b1, 1'b1, 24'd1, 8'hFF, 1'b0, 1'b0, '0, '0);
        step(1);
        reset = 1'b1;
        idleInputs();
        step(1);
        step(1);
        reset = 1'b0;
        step(2);
        checkOutput("abort_no_write", wr_count - wr_before, 0);
        checkOutput("abort_no_ack", a_ack_count - a_before, 0);
        runTransaction(1'b0, 1'b0, 24'd1, 8'd0, lat);
        checkOutput("abort_readback", a_rdata, 8'd89);
        step(1);

        $display("[TB] abandoned request on B");
        b_before = b_ack_count;
        applyStimulus(1'b1, 1'b0, 24'd7, 8'd0, 1'b0, 1'b0, '0, '0);
        step(1);
        applyStimulus(1'b1, 1'b0, 24'd7, 8'd0, 1'b1, 1'b0, 24'd2, 8'd0);
        step(1);
        checkOutput("abandon_a_ack", a_ack, 1'b1);
        idleInputs();
        step(4);
        checkOutput("abandon_no_b_ack", b_ack_count - b_before, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
